// File: rtl/button_debouncer.sv
// Button debouncer: two-flop synchroniser, prescaled stability check, registered level and edge pulses.
// Optional define DEBOUNCE_GLITCH_CNT_EN adds a saturating glitch_cnt output counting aborted checks.
module button_debouncer #(
    parameter int CLK_DIV        = 4,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_rise,
    output logic       btn_fall,
    output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        LOW,
        CHK_HIGH,
        HIGH,
        CHK_LOW
    } state_t;

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES + 1) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

    state_t        state;
    logic          s1;
    logic          s2;
    logic [PW-1:0] pre;
    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = (pre == PRE_MAX);

    // NOTE: every register here uses non-blocking assignment so all reads see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            state     <= LOW;
            pre       <= '0;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
            busy      <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            glitch_cnt <= 8'd0;
`endif
        end else begin
            s1       <= btn_in;
            s2       <= s1;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            pre      <= tick ? '0 : pre + 1'b1;

            unique case (state)
                LOW: begin
                    if (s2) begin
                        state <= CHK_HIGH;
                        pre   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CHK_HIGH: begin
                    if (!s2) begin
                        state <= LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
`endif
                    end else if (tick) begin
                        if (cnt == CNT_LAST) begin
                            state     <= HIGH;
                            btn_level <= 1'b1;
                            btn_rise  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= CHK_LOW;
                        pre   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CHK_LOW: begin
                    // Mirror of CHK_HIGH; btn_level keeps its old value until acceptance.
                    if (s2) begin
                        state <= HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
`endif
                    end else if (tick) begin
                        if (cnt == CNT_LAST) begin
                            state     <= LOW;
                            btn_level <= 1'b0;
                            btn_fall  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= LOW;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
